// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: sizing functions,
// a parameter sanity helper and the reset value of the read data port.
package fifo_pkg;

  // Ceiling log2, usable in constant expressions (value 1 gives 0).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  // True for powers of two that are at least 2.
  function automatic logic is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Every bit of data_out takes this value on reset.
  localparam logic DOUT_RST_BIT = 1'b0;

endpackage

// File: rtl/fifo_mem_dp.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the write word at the write index on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow, synchronous
// flush and an optional first-word-fall-through read path.
//
// Handshake: a write is taken on a rising edge when wr=1 and the FIFO is
// not full, or is full but a read is taken on the same edge. A read is
// taken when rd=1 and the FIFO is not empty. A request that is not taken
// has no effect on contents or count and only sets its sticky error flag.
// clear wins over wr/rd; rst wins over everything.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      wr,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      rd,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AEMPTY_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [DATA_WIDTH-1:0] DOUT_RST = {DATA_WIDTH{DOUT_RST_BIT}};

  // Reject illegal configurations at elaboration.
  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH=%0d must be a power of 2 and >= 2", DEPTH);
    end
    if ((AFULL_THRESH < 0) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
      $error("fifo_sync_param: AFULL_THRESH=%0d outside 0..DEPTH", AFULL_THRESH);
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH)) begin : g_bad_aempty
      $error("fifo_sync_param: AEMPTY_THRESH=%0d outside 0..DEPTH", AEMPTY_THRESH);
    end
  endgenerate

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  empty_q;
  logic                  full_q;
  logic                  aempty_q;
  logic                  afull_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Accept decisions and next-state occupancy; a full FIFO can still take
  // a write when the same edge pops a word.
  always_comb begin
    rd_ok   = rd && !empty_q;
    wr_ok   = wr && (!full_q || rd_ok);
    cnt_nxt = cnt_q;
    if (clear) begin
      cnt_nxt = '0;
    end else if (wr_ok && !rd_ok) begin
      cnt_nxt = cnt_q + CNT_ONE;
    end else if (rd_ok && !wr_ok) begin
      cnt_nxt = cnt_q - CNT_ONE;
    end
  end

  // Pointers, count and registered flags; flags follow the next count so
  // they line up with count in the cycle after the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      cnt_q    <= cnt_nxt;
      empty_q  <= (cnt_nxt == '0);
      full_q   <= (cnt_nxt == DEPTH_C);
      aempty_q <= (cnt_nxt <= AE_C);
      afull_q  <= (cnt_nxt >= AF_C);
      if (wr && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (rd && empty_q) begin
        unf_q <= 1'b1;
      end
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok && !clear),
    .waddr (wr_ptr[IDX_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; the reset value is shown while empty.
      assign data_out = empty_q ? DOUT_RST : mem_rdata;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      // Capture the head word on an accepted read, hold it otherwise.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q <= DOUT_RST;
        end else if (!clear && rd_ok) begin
          dout_q <= mem_rdata;
        end
      end
      assign data_out = dout_q;
    end
  endgenerate

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, next generation of the 8-bit sync FIFO.
- Adds configurable width and depth.
- Adds an occupancy count and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks in the same clock domain.

Parameters:
- DATA_WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of 2, >=2.
- AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH.
- FWFT, 0, 0 = registered read (data after rd); 1 = head word visible on data_out while !empty.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; empties FIFO, clears error flags.
- wr  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd  in  1  read request.
- data_out  out  DATA_WIDTH  read data.
- empty  out  1  no entries.
- full  out  1  DEPTH entries.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- almost_full  out  1  count >= AFULL_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst=0, async):
  - Pointers, count, overflow and underflow go to 0.
  - data_out goes to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty when pointers are equal; full when the index bits are equal and the MSBs differ.
  - Wrap from DEPTH-1 to 0 is natural binary rollover.
- Write accepted (wr_ok) = wr && (!full || rd_ok). Write stores data_in at wr_ptr and increments wr_ptr.
- Read accepted (rd_ok) = rd && !empty. Read increments rd_ptr.
- count next state:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither.
- Flags empty/full/almost_* are registered and derived from the next-state count, so they are valid in the cycle after the causing edge.
- Simultaneous rd+wr:
  - When full: both are accepted, count stays DEPTH, overflow is not set.
  - When empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- Error flags:
  - wr && !wr_ok sets overflow; data is dropped and state is unchanged.
  - rd && empty sets underflow.
  - Both flags stay set until clear or reset.
- FWFT=0 read path:
  - On rd_ok, data_out <= mem[rd_ptr]. Latency is 1 cycle.
  - data_out holds its value otherwise, including on a rejected read.
- FWFT=1 read path:
  - data_out = mem[rd_ptr] whenever !empty; rd acts as an acknowledge/pop.
  - data_out is don't-care while empty; the bench must not check it then.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- clear:
  - Pointers and count go to 0; flags return to their reset values.
  - wr/rd in the same cycle are ignored.
  - data_out is unchanged in FWFT=0.
  - clear has priority over wr/rd; rst has priority over everything.
- Reset mid-operation: all contents are lost; after rst deasserts, the FIFO is empty, with no spurious data or flags.
- Elaboration check: DEPTH not a power of 2, or a threshold outside 0..DEPTH, causes a $error at elaboration.

Decomposition:
- Package fifo_pkg holds:
  - function clog2;
  - localparam-style helpers for PTR_W = clog2(DEPTH)+1 and CNT_W;
  - the reset value of data_out.
- Sub-module fifo_mem_dp:
  - DATA_WIDTH x DEPTH register array;
  - one synchronous write port;
  - one asynchronous read port indexed by rd_ptr.
- The top level holds the pointers, count, flags, and the FWFT/registered output mux.

Test Plan:
Defaults unless noted: DATA_WIDTH=8, DEPTH=4, AFULL_THRESH=3, AEMPTY_THRESH=1, FWFT=0.
1. Reset, then write 0x11,0x22,0x33,0x44 back-to-back -> count 1,2,3,4; almost_full after the 3rd; full=1 after the 4th; empty=0. Then 4 reads -> data_out 0x11,0x22,0x33,0x44 one cycle after each rd; empty=1 at the end.
2. Fill to full, then wr 0x55 -> overflow=1, count stays 4; subsequent reads return 0x11..0x44 and 0x55 never appears. Then clear -> count=0, overflow=0, empty=1.
3. Empty FIFO, rd=1 -> underflow=1, data_out unchanged. Same-cycle rd+wr 0x66 on empty -> count=1, the next read returns 0x66.
4. Full FIFO, simultaneous rd+wr 0x77 for 6 cycles -> count stays 4, full stays 1, no overflow; reads span pointer wraparound and drain in order ending with 0x77.
5. FWFT=1: write 0xA1 into empty -> data_out=0xA1 the next cycle with no rd. Write 0xA2, pulse rd -> data_out=0xA2 the following cycle.
6. Write 3 words, assert rst=0 mid-stream for one cycle -> count=0, empty=1, flags 0, data_out=0. Then write/read 0x99 -> returned correctly.
